// File: rtl/fb_arb_pkg.sv
// Shared types and framebuffer geometry for the
// framebuffer write arbiter.
package fb_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_e;

  localparam int FB_WIDTH  = 240;
  localparam int FB_HEIGHT = 160;
  localparam int FB_PIXELS = FB_WIDTH * FB_HEIGHT;

  localparam int DEF_NREQ      = 3;
  localparam int DEF_ADDR_W    = 19;
  localparam int DEF_DATA_W    = 24;
  localparam int DEF_BURST_MAX = 16;
  localparam int STAT_W        = 16;

  // True when a write address falls outside the
  // visible framebuffer.
  function automatic logic addr_oob(
    input logic [31:0] a
  );
    return a >= 32'(FB_PIXELS);
  endfunction

endpackage

// File: rtl/vs_edge_sync.sv
// Two-flop VGA_VS synchroniser with a one-cycle
// pulse on the synchronised falling edge.
module vs_edge_sync (
  input  logic Clk,
  input  logic Reset,
  input  logic VGA_VS,
  output logic frameStart
);

  logic [1:0] sync_q;
  logic       prev_q;

  // Sync chain and edge history idle high
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      sync_q <= 2'b11;
      prev_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[0], VGA_VS};
      prev_q <= sync_q[1];
    end
  end

  assign frameStart = prev_q & ~sync_q[1];

endmodule

// File: rtl/fb_write_arbiter.sv
// Round-robin burst arbiter onto the framebuffer
// write port. Option: FB_ARB_STATS_EN (beat counters).
module fb_write_arbiter
  import fb_arb_pkg::*;
#(
  parameter int NREQ      = DEF_NREQ,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int BURST_MAX = DEF_BURST_MAX
) (
  input  logic                        Clk,
  input  logic                        Reset,
  input  logic                        VGA_VS,
  input  logic                        WinEn,
  input  logic [NREQ-1:0]             req,
  input  logic [NREQ-1:0]             last,
  input  logic [NREQ-1:0][ADDR_W-1:0] addr,
  input  logic [NREQ-1:0][DATA_W-1:0] data,
  output logic [NREQ-1:0]             gnt,
  output logic                        FBwe,
  output logic [ADDR_W-1:0]           FBwrite_address,
  output logic [DATA_W-1:0]           FBdata_In,
  output logic [1:0]                  owner,
  output logic                        busy,
  output logic                        frameStart,
  output logic                        errOob,
  output logic [NREQ-1:0][STAT_W-1:0] beatCnt
);

  localparam int BW = $clog2(BURST_MAX + 1);

  arb_state_e        state_q, state_d;
  logic [1:0]        owner_q, owner_d;
  logic [1:0]        last_q, last_d;
  logic [BW-1:0]     bcnt_q, bcnt_d;
  logic              frame_start;
  logic              sel_req, sel_last;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;
  logic [1:0]        winner;
  logic              win_ok;
  logic              accept, oob;
  logic              beat_done, drop;

  vs_edge_sync u_vs (
    .Clk        (Clk),
    .Reset      (Reset),
    .VGA_VS     (VGA_VS),
    .frameStart (frame_start)
  );

  assign frameStart = frame_start;
  assign owner      = owner_q;
  assign busy       = (state_q == BURST);

  // Route the current owner's lines
  always_comb begin
    sel_req  = 1'b0;
    sel_last = 1'b0;
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (owner_q == 2'(i)) begin
        sel_req  = req[i];
        sel_last = last[i];
        sel_addr = addr[i];
        sel_data = data[i];
      end
    end
  end

  // Round-robin pick after the previous owner
  always_comb begin
    int idx;
    idx    = 0;
    winner = '0;
    win_ok = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(last_q) + k) % NREQ;
      if (!win_ok && req[idx]) begin
        winner = 2'(idx);
        win_ok = 1'b1;
      end
    end
  end

  assign accept = busy && WinEn && sel_req;
  assign oob    = addr_oob(32'(sel_addr));
  assign drop   = busy && WinEn && !sel_req;
  assign beat_done = accept &&
    (sel_last || bcnt_q == BW'(BURST_MAX - 1));

  // One-hot grant follows the window in BURST
  always_comb begin
    gnt = '0;
    for (int i = 0; i < NREQ; i++) begin
      gnt[i] = busy && WinEn &&
               (owner_q == 2'(i));
    end
  end

  // Next-state: grant, count, release, abort
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    bcnt_d  = bcnt_q;
    unique case (state_q)
      IDLE: begin
        if (!frame_start && WinEn && win_ok) begin
          state_d = BURST;
          owner_d = winner;
          bcnt_d  = '0;
        end
      end
      BURST: begin
        if (accept) bcnt_d = bcnt_q + 1'b1;
        if (beat_done || drop) begin
          state_d = IDLE;
          last_d  = owner_q;
        end
      end
    endcase
    if (frame_start) begin
      state_d = IDLE;
      last_d  = 2'(NREQ - 1);
    end
  end

  // Arbiter state registers
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      owner_q <= '0;
      last_q  <= 2'(NREQ - 1);
      bcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      bcnt_q  <= bcnt_d;
    end
  end

  // Registered write port, OOB beats swallowed
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      FBwe            <= 1'b0;
      FBwrite_address <= '0;
      FBdata_In       <= '0;
    end else begin
      FBwe <= accept && !oob;
      if (accept) begin
        FBwrite_address <= sel_addr;
        FBdata_In       <= sel_data;
      end
    end
  end

  // Sticky OOB flag; a new OOB beat beats the clear
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset)
      errOob <= 1'b0;
    else if (accept && oob)
      errOob <= 1'b1;
    else if (frame_start)
      errOob <= 1'b0;
  end

`ifdef FB_ARB_STATS_EN
  logic [NREQ-1:0][STAT_W-1:0] cnt_q;

  // Saturating per-requester beat counters
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      cnt_q <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (frame_start)
          cnt_q[i] <= '0;
        else if (accept && owner_q == 2'(i) &&
                 cnt_q[i] != '1)
          cnt_q[i] <= cnt_q[i] + 1'b1;
      end
    end
  end

  assign beatCnt = cnt_q;
`else
  assign beatCnt = '0;
`endif

endmodule
